// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// seq_det_ctrl : serial pattern detector with configurable pattern, overlap
//                mode and match budget. Optional idle timeout is compiled in
//                when SEQ_DET_CTRL_TIMEOUT_EN is defined.
// Revision     : 1.0
// ============================================================================
module seq_det_ctrl #(
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 8,
  parameter int TO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             timeout
);

  localparam int c_FILL_W = $clog2(PAT_W + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_W);
  localparam logic [PAT_W-1:0]    c_RST_PAT  = PAT_W'(8'h2F);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state, w_state_n;
  logic [PAT_W-1:0]    r_hist, w_hist_n, w_shift, w_mask;
  logic [c_FILL_W-1:0] r_fill, w_fill_n;
  logic [CNT_W-1:0]    r_count, w_count_n;
  logic                r_match, w_match_n;
  logic                r_busy, r_done, r_err;
  logic [PAT_W-1:0]    r_cfg_pat;
  logic [3:0]          r_cfg_len;
  logic                r_cfg_ovl;
  logic [CNT_W-1:0]    r_cfg_lim;
  logic                w_len_ok, w_hit;

  assign w_shift  = {r_hist[PAT_W-2:0], bit_in};
  assign w_len_ok = (cfg_len != 4'd0) && (int'(cfg_len) <= PAT_W);

  always_comb begin
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_cfg_len));
    end
  end

  // The current bit counts toward the fill, hence the +1.
  assign w_hit = ((32'(r_fill) + 32'd1) >= 32'(r_cfg_len)) &&
                 ((w_shift & w_mask) == (r_cfg_pat & w_mask));

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  localparam int c_TO_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  logic [c_TO_W-1:0] r_tocnt, w_tocnt_n;
  logic              r_timeout, w_timeout_n;
  assign timeout = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = (TO_CYC == 0);
  assign timeout     = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_hist_n  = r_hist;
    w_fill_n  = r_fill;
    w_count_n = r_count;
    w_match_n = 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    w_timeout_n = 1'b0;
    w_tocnt_n   = r_tocnt;
`endif
    if (abort) begin
      w_state_n = S_IDLE;
    end else if (start && (r_state != S_ARMED)) begin
      w_state_n = S_ARMED;
      w_hist_n  = '0;
      w_fill_n  = '0;
      w_count_n = '0;
    end else if (r_state == S_ARMED) begin
      if (bit_valid) begin
        w_hist_n = w_shift;
        if (r_fill != c_FILL_MAX) w_fill_n = r_fill + 1'b1;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        w_tocnt_n = '0;
`endif
        if (w_hit) begin
          w_match_n = 1'b1;
          if (r_count != '1) w_count_n = r_count + 1'b1;
          if (!r_cfg_ovl) w_fill_n = '0;
          if ((r_cfg_lim != '0) && (w_count_n == r_cfg_lim)) w_state_n = S_DONE;
        end
      end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
      else if ((32'(r_tocnt) + 32'd1) == 32'(TO_CYC)) begin
        w_timeout_n = 1'b1;
        w_state_n   = S_IDLE;
      end else begin
        w_tocnt_n = r_tocnt + 1'b1;
      end
`endif
    end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    if (w_state_n != r_state) w_tocnt_n = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hist    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_match   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cfg_pat <= c_RST_PAT;
      r_cfg_len <= 4'd6;
      r_cfg_ovl <= 1'b1;
      r_cfg_lim <= '0;
    end else begin
      r_state <= w_state_n;
      r_hist  <= w_hist_n;
      r_fill  <= w_fill_n;
      r_count <= w_count_n;
      r_match <= w_match_n;
      r_busy  <= (w_state_n == S_ARMED);
      r_done  <= (w_state_n == S_DONE);
      r_err   <= 1'b0;
      if (cfg_we) begin
        if ((r_state == S_IDLE) && w_len_ok) begin
          r_cfg_pat <= cfg_pattern;
          r_cfg_len <= cfg_len;
          r_cfg_ovl <= cfg_overlap;
          r_cfg_lim <= cfg_limit;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tocnt   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tocnt   <= w_tocnt_n;
      r_timeout <= w_timeout_n;
    end
  end
`endif

  assign match       = r_match;
  assign match_count = r_count;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// tb_seq_det_ctrl : directed stimulus with a match scoreboard for seq_det_ctrl.
// Revision        : 1.0
// ============================================================================
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_overlap, start, abort, bit_valid, bit_in;
  logic [7:0] cfg_pattern, cfg_limit;
  logic [3:0] cfg_len;
  logic       match, busy, done, err, timeout;
  logic [7:0] match_count;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  bit   saw_to = 1'b0;

  seq_det_ctrl #(.PAT_W(8), .CNT_W(8), .TO_CYC(255)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
    .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
    .match(match), .match_count(match_count), .busy(busy), .done(done),
    .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every match pulse must line up with the head of the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (timeout) saw_to = 1'b1;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_match: no match pulse, required at cycle %0d count %0d", q[0].cyc, q[0].cnt);
        void'(q.pop_front());
      end
      if (match) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_match: match=1 at cycle %0d count %0d, required none", cyc, match_count);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.cnt != int'(match_count)) begin
            n_err++;
            $display("FAIL match: got cycle %0d count %0d, required cycle %0d count %0d",
                     cyc, match_count, e.cyc, e.cnt);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit exp_m, input int exp_c);
    bit_valid = 1'b1;
    bit_in    = b;
    if (exp_m) q.push_back('{cyc + 1, exp_c});
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // bits/mpos are oldest-first from bit n-1 down to bit 0.
  task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] mpos,
                        input int base, input int gap);
    int c;
    c = base;
    for (int i = 0; i < n; i++) begin
      if (mpos[n-1-i]) c++;
      send_bit(bits[n-1-i], mpos[n-1-i], c);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic [7:0] lim);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_limit   = lim;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    int first_to;
    int to_pulses;
    rst = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
    cfg_limit = 0; start = 0; abort = 0; bit_valid = 0; bit_in = 0;
    repeat (3) tick();
    chk("rst_match", match, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_count", match_count, 0);
    rst = 1'b0;
    tick();

    // Default pattern 101111, single match
    pulse_start();
    chk("armed_busy", busy, 1);
    chk("start_count", match_count, 0);
    stream(16'b101111, 6, 16'b000001, 0, 0);
    tick();
    chk("a_count", match_count, 1);
    chk("a_busy", busy, 1);

    // Overlap with idle gaps between bits
    pulse_abort();
    chk("abort_busy", busy, 0);
    chk("abort_count_held", match_count, 1);
    pulse_start();
    stream(16'b10111101111, 11, 16'b00000100001, 0, 2);
    tick();
    chk("ovl_count", match_count, 2);

    // Non-overlap: second candidate lacks fresh bits
    pulse_abort();
    cfg(8'h2F, 4'd6, 1'b0, 8'd0);
    chk("cfg_ok_err", err, 0);
    pulse_start();
    stream(16'b10111101111, 11, 16'b00000100000, 0, 0);
    tick();
    chk("novl_count", match_count, 1);

    // Match budget of 2 with pattern 101
    pulse_abort();
    cfg(8'h05, 4'd3, 1'b1, 8'd2);
    pulse_start();
    stream(16'b10101, 5, 16'b00101, 0, 0);
    chk("lim_done", done, 1);
    chk("lim_busy", busy, 0);
    stream(16'b01, 2, 16'b00, 2, 0);
    chk("lim_count", match_count, 2);
    chk("lim_done_hold", done, 1);

    // Rejected writes leave the 101/len3 configuration intact
    pulse_start();
    chk("restart_busy", busy, 1);
    cfg(8'h00, 4'd4, 1'b0, 8'd0);
    chk("armed_we_err", err, 1);
    tick();
    chk("err_one_cycle", err, 0);
    stream(16'b101, 3, 16'b001, 0, 0);
    pulse_abort();
    cfg(8'h00, 4'd0, 1'b0, 8'd0);
    chk("len0_err", err, 1);
    cfg(8'h00, 4'd9, 1'b0, 8'd0);
    chk("len9_err", err, 1);
    pulse_start();
    stream(16'b101, 3, 16'b001, 0, 0);
    tick();
    chk("cfg_kept_count", match_count, 1);

    // abort wins over start
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", busy, 0);
    tick();
    chk("abort_start_idle", busy, 0);

    // Reset mid-ARMED (defaults restored) with a partial pattern
    rst = 1'b1;
    #1;
    chk("async_rst_count", match_count, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    stream(16'b10111, 5, 16'b00000, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    send_bit(1'b1, 1'b0, 0);
    tick();
    chk("post_rst_count", match_count, 0);
    pulse_abort();

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    pulse_start();
    repeat (199) tick();
    send_bit(1'b0, 1'b0, 0);
    first_to  = 0;
    to_pulses = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (timeout) begin
        to_pulses++;
        if (first_to == 0) first_to = k;
      end
    end
    chk("to_cycle", first_to, 255);
    chk("to_pulses", to_pulses, 1);
    chk("to_idle", busy, 0);
`else
    first_to  = 0;
    to_pulses = 0;
    pulse_start();
    repeat (300) tick();
    chk("no_to_busy", busy, 1);
    chk("no_to_seen", int'(saw_to), 0);
`endif

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter: PAT_W, default 8, the maximum pattern length in bits.
REQ-002 Parameter: CNT_W, default 8, the width of the match counter and of the match limit.
REQ-003 Parameter: TO_CYC, default 255, the idle-bit timeout in clock cycles.
REQ-004 Reset rst is asynchronous and active-high; the clock is clk.
REQ-005 Port list, one per line (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  PAT_W  pattern bits; bit 0 is the most recent bit.
- cfg_len  in  4  pattern length, legal range 1..PAT_W.
- cfg_overlap  in  1  1 = overlapping detection.
- cfg_limit  in  CNT_W  match budget; 0 = unlimited.
- start  in  1  arm the detector.
- abort  in  1  return to IDLE.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial data bit.
- match  out  1  one-cycle registered match pulse.
- match_count  out  CNT_W  matches since the last start.
- busy  out  1  high in ARMED.
- done  out  1  high in DONE.
- err  out  1  one-cycle pulse on a rejected configuration write.
- timeout  out  1  one-cycle pulse when the idle timeout fires.

Function
REQ-006 FSM states are IDLE, ARMED and DONE; all outputs are registered (Moore).
REQ-007 Transition priority each cycle is abort > start > bit processing.
- abort in any state moves to IDLE next cycle and leaves match_count held.
REQ-008 start in IDLE or DONE: clear match_count, the history register and the fill count, then enter ARMED next cycle.
- A bit presented in the start cycle is ignored.
- start in ARMED is ignored.
REQ-009 In ARMED, each bit_valid cycle shifts bit_in into a PAT_W-bit history at bit 0.
- The fill count increments, saturating at PAT_W.
REQ-010 A match occurs when fill+1 >= cfg_len and the low cfg_len bits of {history, bit_in} equal cfg_pattern[cfg_len-1:0].
- match pulses high in the cycle after that bit_valid cycle, so latency is 1.
REQ-011 Overlap mode: history and fill are retained after a match.
- Non-overlap mode: fill clears to 0 on a match, so the next match needs cfg_len fresh bits.
REQ-012 On a match, match_count increments, saturating at all-ones.
- If cfg_limit != 0 and the new count equals cfg_limit, the FSM enters DONE in the same edge as the match pulse.
REQ-013 In DONE, bits are ignored.
- done stays high until start or abort.
REQ-014 cfg_we is accepted only in IDLE and only with 1 <= cfg_len <= PAT_W.
- An accepted write updates all configuration registers on the next edge.
- Otherwise the write is ignored, err pulses for one cycle, and the configuration is unchanged.
REQ-015 Cycles with bit_valid=0 leave the history, fill and count unchanged.

Reset
REQ-016 On rst, the block enters IDLE and every output goes to 0: match, busy, done, err, timeout and match_count.
REQ-017 Reset configuration:
- cfg_pattern = 0x2F (101111, with the oldest bit first);
- cfg_len = 6;
- overlap = 1;
- limit = 0.
REQ-018 Reset clears the history and fill count.
- rst asserted mid-ARMED abandons the partial match without a match pulse.

Configuration
REQ-019 The macro is SEQ_DET_CTRL_TIMEOUT_EN.
- When it is defined, a counter tracks consecutive ARMED cycles with bit_valid=0.
- On reaching TO_CYC, timeout pulses for one cycle and the FSM enters IDLE.
- The counter clears on bit_valid, on any state change and on rst.
REQ-020 When SEQ_DET_CTRL_TIMEOUT_EN is undefined, the timeout port exists but is tied to 0, and ARMED waits indefinitely.

Verification
REQ-021 Reset defaults, start, then stream 1,0,1,1,1,1 (one bit per cycle) -> match pulses once, 1 cycle after the 6th bit; match_count=1.
REQ-022 Defaults (overlap=1), stream 1,0,1,1,1,1,0,1,1,1,1 -> match after bit 6 and bit 11; match_count=2.
- With overlap=0 and the same stream -> only the first match; match_count=1.
REQ-023 Config pattern=0b101, len=3, limit=2, then stream 1,0,1,0,1,0,1 -> matches after bits 3 and 5, done=1 and busy=0 from the 2nd match; the last bits are ignored and the count stays 2.
REQ-024 cfg_we while ARMED, or cfg_we with cfg_len=0 or 9 in IDLE -> err pulses for one cycle and the configuration is unchanged.
- abort asserted with start in the same cycle -> IDLE.
REQ-025 With SEQ_DET_CTRL_TIMEOUT_EN, TO_CYC=255: start, then no bit_valid for 255 cycles -> timeout pulses for one cycle and the FSM is in IDLE.
- A single bit_valid at cycle 200 resets the wait.
- Without the macro, timeout stays 0 throughout.
